// File: rtl/team_06_echo_engine_if.sv
// Sample-stream and ring-buffer SRAM signals of the echo engine.
// The engine connects through the slave modport; source, sink and SRAM connect through master.
interface team_06_echo_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
);
  logic [1:0]        mode;
  logic [3:0]        decay;
  logic [ADDR_W-1:0] delay_in;
  logic [DATA_W-1:0] audio_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_ack;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ack;
  logic [DATA_W-1:0] echo_out;
  logic              out_valid;

  modport slave (
    input  mode, decay, delay_in, audio_in, sample_valid,
    input  mem_rd_data, mem_rd_ack, mem_wr_ack,
    output sample_ready, mem_rd_req, mem_rd_addr,
    output mem_wr_req, mem_wr_addr, mem_wr_data,
    output echo_out, out_valid
  );

  modport master (
    output mode, decay, delay_in, audio_in, sample_valid,
    output mem_rd_data, mem_rd_ack, mem_wr_ack,
    input  sample_ready, mem_rd_req, mem_rd_addr,
    input  mem_wr_req, mem_wr_addr, mem_wr_data,
    input  echo_out, out_valid
  );
endinterface

// File: rtl/team_06_echo_engine.sv
// Echo/reverb engine: mixes each accepted sample with the one DELAY positions back
// in an external SRAM ring buffer and writes back the dry or the mixed sample.
module team_06_echo_engine #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 13,
  parameter int DEF_DELAY = 8000
) (
  input  logic                   clk,
  input  logic                   n_rst,
  team_06_echo_engine_if.slave   bus
);

  localparam int DLY_W = 32;
  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_REVERB = 2'b10;
  localparam logic [ADDR_W-1:0] FILL_MAX = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_MIX  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Weighted mix in sixteenths; the sum never exceeds (2**DATA_W-1)*16, so DATA_W+4 bits suffice.
  function automatic logic [DATA_W-1:0] mix_f(
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] old,
    input logic [3:0]        g
  );
    logic [DATA_W+3:0] dry_s;
    logic [DATA_W+3:0] wet_s;
    logic [DATA_W+3:0] sum_s;
    dry_s = (DATA_W+4)'(cur) * (DATA_W+4)'(5'd16 - {1'b0, g});
    wet_s = (DATA_W+4)'(old) * (DATA_W+4)'(g);
    sum_s = dry_s + wet_s;
    return DATA_W'(sum_s >> 4);
  endfunction

  state_t            state_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] fill_r;
  logic [DATA_W-1:0] in_r;
  logic [1:0]        mode_r;
  logic [3:0]        decay_r;
  logic [DATA_W-1:0] past_r;
  logic [DATA_W-1:0] result_r;
  logic              sample_ready_r;
  logic              rd_req_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              wr_req_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [DATA_W-1:0] echo_out_r;
  logic              out_valid_r;

  logic [DLY_W-1:0]  eff_delay_s;
  logic              accept_s;
  logic              warm_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] mix_s;

  // Effective delay, warm-up decision and read address for the sample on offer
  always_comb begin
    eff_delay_s = DLY_W'(DEF_DELAY);
    if (bus.delay_in != {ADDR_W{1'b0}}) begin
      eff_delay_s = DLY_W'(bus.delay_in);
    end else begin
      eff_delay_s = DLY_W'(DEF_DELAY);
    end
    accept_s  = bus.sample_valid && sample_ready_r;
    // Full-width compare: delays beyond the buffer depth stay in warm-up forever
    warm_s    = DLY_W'(fill_r) < eff_delay_s;
    rd_addr_s = wr_ptr_r - eff_delay_s[ADDR_W-1:0];
    mix_s     = mix_f(in_r, past_r, decay_r);
  end

  // Transaction sequencer with all outputs registered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r        <= S_IDLE;
      wr_ptr_r       <= {ADDR_W{1'b0}};
      fill_r         <= {ADDR_W{1'b0}};
      in_r           <= {DATA_W{1'b0}};
      mode_r         <= 2'b00;
      decay_r        <= 4'd0;
      past_r         <= {DATA_W{1'b0}};
      result_r       <= {DATA_W{1'b0}};
      sample_ready_r <= 1'b1;
      rd_req_r       <= 1'b0;
      rd_addr_r      <= {ADDR_W{1'b0}};
      wr_req_r       <= 1'b0;
      wr_addr_r      <= {ADDR_W{1'b0}};
      wr_data_r      <= {DATA_W{1'b0}};
      echo_out_r     <= {DATA_W{1'b0}};
      out_valid_r    <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            in_r           <= bus.audio_in;
            mode_r         <= bus.mode;
            decay_r        <= bus.decay;
            sample_ready_r <= 1'b0;
            if (bus.mode == MODE_BYPASS) begin
              result_r <= bus.audio_in;
              state_r  <= S_DONE;
            end else if (warm_s) begin
              past_r  <= {DATA_W{1'b0}};
              state_r <= S_MIX;
            end else begin
              rd_req_r  <= 1'b1;
              rd_addr_r <= rd_addr_s;
              state_r   <= S_RD;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RD: begin
          if (bus.mem_rd_ack) begin
            past_r   <= bus.mem_rd_data;
            rd_req_r <= 1'b0;
            state_r  <= S_MIX;
          end else begin
            state_r <= S_RD;
          end
        end
        S_MIX: begin
          result_r  <= mix_s;
          wr_req_r  <= 1'b1;
          wr_addr_r <= wr_ptr_r;
          wr_data_r <= (mode_r == MODE_REVERB) ? mix_s : in_r;
          state_r   <= S_WR;
        end
        S_WR: begin
          if (bus.mem_wr_ack) begin
            wr_req_r <= 1'b0;
            wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            if (fill_r != FILL_MAX) begin
              fill_r <= fill_r + ADDR_W'(1);
            end else begin
              fill_r <= fill_r;
            end
            state_r <= S_DONE;
          end else begin
            state_r <= S_WR;
          end
        end
        S_DONE: begin
          echo_out_r     <= result_r;
          out_valid_r    <= 1'b1;
          sample_ready_r <= 1'b1;
          state_r        <= S_IDLE;
        end
        default: begin
          rd_req_r       <= 1'b0;
          wr_req_r       <= 1'b0;
          sample_ready_r <= 1'b1;
          state_r        <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sample_ready = sample_ready_r;
  assign bus.mem_rd_req   = rd_req_r;
  assign bus.mem_rd_addr  = rd_addr_r;
  assign bus.mem_wr_req   = wr_req_r;
  assign bus.mem_wr_addr  = wr_addr_r;
  assign bus.mem_wr_data  = wr_data_r;
  assign bus.echo_out     = echo_out_r;
  assign bus.out_valid    = out_valid_r;

endmodule

// File: tb/tb_team_06_echo_engine.sv
// Bench for team_06_echo_engine: a sample-level model predicts outputs, latency and
// memory traffic, checked every cycle, plus literal expectations for directed cases.
module tb_team_06_echo_engine;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  team_06_echo_engine_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  team_06_echo_engine #(.DATA_W(8), .ADDR_W(4), .DEF_DELAY(3)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // SRAM model with programmable ack wait
  logic [7:0] sram [16];
  int rd_wait = 0, wr_wait = 0, rd_cnt = 0, wr_cnt = 0;
  logic pre_en = 1'b0;
  logic [3:0] pre_addr = 4'd0;
  logic [7:0] pre_val = 8'd0;

  assign bus.mem_rd_ack  = bus.mem_rd_req && (rd_cnt >= rd_wait);
  assign bus.mem_wr_ack  = bus.mem_wr_req && (wr_cnt >= wr_wait);
  assign bus.mem_rd_data = sram[bus.mem_rd_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_cnt <= (bus.mem_rd_req && !bus.mem_rd_ack) ? rd_cnt + 1 : 0;
    wr_cnt <= (bus.mem_wr_req && !bus.mem_wr_ack) ? wr_cnt + 1 : 0;
    if (bus.mem_wr_req && bus.mem_wr_ack) sram[bus.mem_wr_addr] <= bus.mem_wr_data;
    else if (pre_en) sram[pre_addr] <= pre_val;
  end

  // Sample-level model of the engine
  int m_buf [16];
  int m_wr_ptr = 0, m_fill = 0, m_hold = 0;
  // Expectation for the transaction in flight
  bit t_active = 1'b0, t_has_rd = 1'b0, t_has_wr = 1'b0;
  int t_out, t_rd_addr, t_wr_addr, t_wr_data, t_acc, t_due;
  // Observations for literal checks
  int last_out = -1, last_lat = -1, last_rd_addr = -1, last_wr_addr = -1, last_wr_data = -1;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_buf[i] = 0;
    m_wr_ptr = 0;
    m_fill = 0;
    m_hold = 0;
    t_active = 1'b0;
  endtask

  // Per-cycle comparison against the model
  initial begin
    int exp_v, exp_e, exp_r;
    forever begin
      @(negedge clk);
      if (t_active && cyc == t_due) begin exp_v = 1; exp_e = t_out; end
      else begin exp_v = 0; exp_e = m_hold; end
      exp_r = (!t_active || cyc >= t_due) ? 1 : 0;
      chk("out_valid", int'(bus.out_valid), exp_v);
      chk("echo_out", int'(bus.echo_out), exp_e);
      chk("sample_ready", int'(bus.sample_ready), exp_r);
      chk("req_exclusive", int'(bus.mem_rd_req && bus.mem_wr_req), 0);
      if (bus.mem_rd_req) begin
        chk("rd_req_allowed", int'(t_active && t_has_rd), 1);
        chk("rd_addr", int'(bus.mem_rd_addr), t_rd_addr);
        last_rd_addr = int'(bus.mem_rd_addr);
      end
      if (bus.mem_wr_req) begin
        chk("wr_req_allowed", int'(t_active && t_has_wr), 1);
        chk("wr_addr", int'(bus.mem_wr_addr), t_wr_addr);
        chk("wr_data", int'(bus.mem_wr_data), t_wr_data);
        last_wr_addr = int'(bus.mem_wr_addr);
        last_wr_data = int'(bus.mem_wr_data);
      end
      if (bus.out_valid) begin
        last_out = int'(bus.echo_out);
        last_lat = cyc - t_acc;
      end
      if (exp_v == 1) begin
        m_hold = t_out;
        t_active = 1'b0;
      end
    end
  end

  task automatic preload(input int a, input int v);
    pre_addr = 4'(a);
    pre_val = 8'(v);
    pre_en = 1'b1;
    m_buf[a] = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    bus.sample_valid = 1'b0;
    rd_wait = 0;
    wr_wait = 0;
    model_reset();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic send(input int s, input int md, input int g, input int dly,
                      input int rdw, input int wrw, input int hold, input bit wait_done);
    int n, eff, past, mix, lat;
    bit warm;
    n = 0;
    @(negedge clk);
    while (!bus.sample_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("ready_timeout", 0, 1);
    rd_wait = rdw;
    wr_wait = wrw;
    bus.audio_in = 8'(s);
    bus.mode = 2'(md);
    bus.decay = 4'(g);
    bus.delay_in = 4'(dly);
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    eff = (dly == 0) ? 3 : dly;
    if (md == 0) begin
      t_out = s; t_has_rd = 1'b0; t_has_wr = 1'b0; lat = 1;
    end else begin
      warm = (m_fill < eff);
      t_rd_addr = (m_wr_ptr - eff + 16) % 16;
      past = warm ? 0 : m_buf[t_rd_addr];
      mix = (s * (16 - g) + past * g) / 16;
      t_out = mix;
      t_has_rd = !warm;
      t_has_wr = 1'b1;
      t_wr_addr = m_wr_ptr;
      t_wr_data = (md == 2) ? mix : s;
      m_buf[m_wr_ptr] = t_wr_data;
      m_wr_ptr = (m_wr_ptr + 1) % 16;
      if (m_fill < 15) m_fill++;
      lat = warm ? 3 + wrw : 4 + rdw + wrw;
    end
    t_acc = cyc;
    t_due = cyc + lat;
    t_active = 1'b1;
    if (hold > 0) begin
      bus.audio_in = 8'hEE;
      repeat (hold) begin @(posedge clk); #1; end
    end
    bus.sample_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (t_active && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("done_timeout", 0, 1);
    end
  endtask

  int echo_in [4] = '{10, 20, 30, 40};
  int echo_exp [4] = '{5, 10, 15, 25};
  int rev_exp [6] = '{80, 80, 80, 120, 120, 120};
  int ech_exp [4] = '{80, 80, 80, 160};

  initial begin
    bus.audio_in = 8'd0;
    bus.mode = 2'b01;
    bus.decay = 4'd0;
    bus.delay_in = 4'd0;
    bus.sample_valid = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_ready", int'(bus.sample_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_echo_out", int'(bus.echo_out), 0);
    chk("rst_rd_req", int'(bus.mem_rd_req), 0);
    chk("rst_wr_req", int'(bus.mem_wr_req), 0);
    do_reset();

    // Warm-up then first real read, DEF_DELAY via delay_in = 0
    for (int i = 0; i < 4; i++) begin
      send(echo_in[i], 1, 8, 0, 0, 0, 0, 1'b1);
      chk("echo_seq_out", last_out, echo_exp[i]);
    end
    chk("first_rd_addr", last_rd_addr, 0);
    chk("first_read_latency", last_lat, 4);

    // Mix arithmetic with pre-filled buffer
    preload(3, 100);
    send(200, 1, 8, 1, 0, 0, 0, 1'b1);
    chk("mix_200_100_g8", last_out, 150);
    preload(4, 255);
    send(0, 1, 15, 1, 0, 0, 0, 1'b1);
    chk("mix_0_255_g15", last_out, 239);
    send(77, 1, 0, 1, 0, 0, 0, 1'b1);
    chk("mix_g0", last_out, 77);

    // Bypass, then ECHO resumes at the same write pointer
    send(99, 0, 8, 0, 0, 0, 0, 1'b1);
    chk("bypass_out", last_out, 99);
    chk("bypass_latency", last_lat, 1);
    send(50, 1, 4, 2, 0, 0, 0, 1'b1);
    chk("after_bypass_wr_addr", last_wr_addr, 7);
    chk("after_bypass_out", last_out, 37);

    // Ack stalls with sample_valid held while busy
    send(60, 1, 8, 0, 5, 2, 3, 1'b1);
    chk("stall_latency", last_lat, 11);
    chk("stall_out", last_out, 30);

    // Pointer wrap
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      send(10 + k, 1, 4, 3, 0, 0, 0, 1'b1);
      if (k == 17) begin
        chk("wrap_rd_addr", last_rd_addr, 13);
        chk("wrap_wr_addr", last_wr_addr, 0);
      end
    end

    // REVERB writes back the mix
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(160, 2, 8, 3, 0, 0, 0, 1'b1);
      chk("reverb_out", last_out, rev_exp[i]);
      chk("reverb_wr_data", last_wr_data, rev_exp[i]);
    end

    // ECHO (mode 11 aliases ECHO) writes back the dry sample
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(160, (i % 2 == 0) ? 1 : 3, 8, 3, 0, 0, 0, 1'b1);
      chk("echo_out_seq", last_out, ech_exp[i]);
      chk("echo_wr_data", last_wr_data, 160);
    end

    // Reset while a read is outstanding
    send(100, 1, 8, 3, 50, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rd_req_pending", int'(bus.mem_rd_req), 1);
    #2;
    n_rst = 1'b0;
    bus.sample_valid = 1'b0;
    rd_wait = 0;
    model_reset();
    #1;
    chk("rst_drops_rd_req", int'(bus.mem_rd_req), 0);
    chk("rst_no_out_valid", int'(bus.out_valid), 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(bus.sample_ready), 1);
    send(40, 1, 8, 3, 0, 0, 0, 1'b1);
    chk("post_rst_wr_addr", last_wr_addr, 0);
    chk("post_rst_out", last_out, 20);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
